// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT core scheduler: FSM states,
// requester port indices and transform direction encodings.
package fft_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    UNLOAD
  } state_t;

  localparam int PORT_FWD = 0;
  localparam int PORT_INV = 1;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_INV = 1'b1;

endpackage

// File: rtl/fft_core_scheduler_if.sv
// Path-side handshake and core-side control bus of the FFT core scheduler.
// master = scheduler, slave = requesting paths plus the fft core.
interface fft_core_scheduler_if #(
  parameter int NB        = 18,
  parameter int LOG_DEPTH = 9
);
  logic [1:0]           req;
  logic [1:0]           gnt;
  logic                 in_valid;
  logic [2*NB-1:0]      in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [2*NB-1:0]      out_data;
  logic                 out_last;
  logic                 core_ready;
  logic                 core_done;
  logic                 core_read_valid;
  logic [2*NB-1:0]      core_read_data;
  logic                 core_start;
  logic                 core_direction;
  logic                 core_real_mode;
  logic                 core_write_enable;
  logic                 core_read_enable;
  logic [3:0]           core_log_depth;
  logic [LOG_DEPTH-1:0] core_address;
  logic [2*NB-1:0]      core_write_data;

  modport master (
    input  req, in_valid, in_data, core_ready, core_done, core_read_valid, core_read_data,
    output gnt, in_ready, out_valid, out_data, out_last, core_start, core_direction,
           core_real_mode, core_write_enable, core_read_enable, core_log_depth,
           core_address, core_write_data
  );

  modport slave (
    output req, in_valid, in_data, core_ready, core_done, core_read_valid, core_read_data,
    input  gnt, in_ready, out_valid, out_data, out_last, core_start, core_direction,
           core_real_mode, core_write_enable, core_read_enable, core_log_depth,
           core_address, core_write_data
  );

endinterface

// File: rtl/fft_core_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; prio_reg names the port that wins a tie
// and flips away from the winner on each update strobe.
module rr_arbiter2
  import fft_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic prio_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign gnt[gi] = req[gi] & (~req[1-gi] | (prio_reg == 1'(gi)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_reg <= 1'(PORT_FWD);
    end else if (update) begin
      prio_reg <= gnt[PORT_FWD] ? 1'(PORT_INV) : 1'(PORT_FWD);
    end
  end

endmodule

// File: rtl/fft_core_scheduler.sv
// Grants the shared fft core to the forward or inverse path and sequences one
// frame load/start/run/unload. FFT_SCHED_TIMEOUT_EN adds a RUN watchdog.
module fft_core_scheduler
  import fft_sched_pkg::*;
#(
  parameter int NB             = 18,
  parameter int LOG_DEPTH      = 9,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_core_scheduler_if.master bus,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [LOG_DEPTH-1:0] LAST_IDX = {LOG_DEPTH{1'b1}};

  state_t               state_reg, state_next;
  logic [1:0]           gnt_reg, arb_gnt;
  logic                 arb_update;
  logic [LOG_DEPTH-1:0] cnt_reg, addr_reg;
  logic                 we_reg, re_reg, start_reg;
  logic [2*NB-1:0]      wdata_reg;
  logic                 accept, beat, last_beat, timeout_hit;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  assign accept    = (state_reg == LOAD) && bus.in_valid;
  assign beat      = (state_reg == UNLOAD) && bus.core_read_valid;
  assign last_beat = beat && (cnt_reg == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    arb_update = 1'b0;
    case (state_reg)
      IDLE: if (|bus.req) begin
        state_next = LOAD;
        arb_update = 1'b1;
      end
      LOAD:   if (accept && (cnt_reg == LAST_IDX)) state_next = START;
      START:  if (bus.core_ready) state_next = RUN;
      RUN: begin
        if (bus.core_done)    state_next = UNLOAD;
        else if (timeout_hit) state_next = IDLE;
      end
      UNLOAD: if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cnt_reg counts accepted samples in LOAD and result beats in UNLOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_reg   <= '0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      re_reg    <= 1'b0;
      start_reg <= 1'b0;
      wdata_reg <= '0;
    end else begin
      we_reg    <= accept;
      start_reg <= (state_reg == START) && bus.core_ready;
      if (accept) begin
        addr_reg  <= cnt_reg;
        wdata_reg <= bus.in_data;
        if (cnt_reg != LAST_IDX) cnt_reg <= cnt_reg + LOG_DEPTH'(1);
      end
      case (state_reg)
        IDLE: if (arb_update) begin
          gnt_reg <= arb_gnt;
          cnt_reg <= '0;
        end
        RUN: begin
          if (bus.core_done) begin
            cnt_reg  <= '0;
            addr_reg <= '0;
            re_reg   <= 1'b1;
          end else if (timeout_hit) begin
            gnt_reg <= '0;
          end
        end
        UNLOAD: begin
          if (addr_reg != LAST_IDX) addr_reg <= addr_reg + LOG_DEPTH'(1);
          if (beat && (cnt_reg != LAST_IDX)) cnt_reg <= cnt_reg + LOG_DEPTH'(1);
          if (last_beat) begin
            re_reg  <= 1'b0;
            gnt_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_SCHED_TIMEOUT_EN
  logic [31:0] wd_reg;
  logic        timeout_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wd_reg      <= (state_reg == RUN) ? wd_reg + 32'd1 : 32'd0;
      timeout_reg <= timeout_hit;
    end
  end

  assign timeout_hit = (state_reg == RUN) && !bus.core_done &&
                       (wd_reg == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign busy                  = (state_reg != IDLE);
  assign bus.gnt               = gnt_reg;
  assign bus.in_ready          = (state_reg == LOAD);
  assign bus.out_valid         = beat;
  assign bus.out_data          = bus.core_read_data;
  assign bus.out_last          = last_beat;
  assign bus.core_start        = start_reg;
  assign bus.core_direction    = gnt_reg[PORT_INV];
  assign bus.core_real_mode    = 1'b0;
  assign bus.core_write_enable = we_reg;
  assign bus.core_read_enable  = re_reg;
  assign bus.core_log_depth    = 4'(LOG_DEPTH);
  assign bus.core_address      = addr_reg;
  assign bus.core_write_data   = wdata_reg;

endmodule

// File: tb/tb_fft_core_scheduler.sv
// Scoreboard bench for fft_core_scheduler with a behavioural fft core model
// (stores frames, returns ~data for inverse direction, done 8 cycles after start).
module tb_fft_core_scheduler;
  import fft_sched_pkg::*;

  localparam int NB = 18;
  localparam int LD = 9;
  localparam int N  = 1 << LD;
  localparam int W  = 2 * NB;

  logic clk = 1'b0;
  logic reset;
  logic busy, timeout_err;

  fft_core_scheduler_if #(.NB(NB), .LOG_DEPTH(LD)) bus ();

  fft_core_scheduler #(.NB(NB), .LOG_DEPTH(LD), .TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] wr_q[$];
  logic [W-1:0] out_q[$];
  int wr_count = 0, wr_base = 0, out_count = 0, out_base = 0, start_count = 0;
  logic start_dir = 1'b0;
  int first_addr = -1;
  bit hang = 1'b0;

  // core model
  logic [W-1:0] mem [N];
  int done_timer;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.core_read_valid <= 1'b0;
      bus.core_read_data  <= '0;
      bus.core_done       <= 1'b0;
      done_timer          <= 0;
    end else begin
      if (bus.core_write_enable) mem[bus.core_address] <= bus.core_write_data;
      bus.core_read_valid <= bus.core_read_enable;
      bus.core_read_data  <= bus.core_direction ? ~mem[bus.core_address] : mem[bus.core_address];
      bus.core_done       <= (done_timer == 1);
      if (bus.core_start && !hang) done_timer <= 8;
      else if (done_timer > 0)     done_timer <= done_timer - 1;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      if (bus.core_write_enable) begin
        tests_run++;
        if (wr_count == wr_base) first_addr = int'(bus.core_address);
        if (wr_q.size() == 0) begin
          tests_failed++;
          $display("FAIL write_unexpected addr=%0d data=%h required no write", bus.core_address, bus.core_write_data);
        end else begin
          e = wr_q.pop_front();
          if (bus.core_address !== LD'(wr_count - wr_base) || bus.core_write_data !== e) begin
            tests_failed++;
            $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                     bus.core_address, bus.core_write_data, wr_count - wr_base, e);
          end
        end
        wr_count++;
      end
      if (bus.core_start) begin
        start_count++;
        start_dir = bus.core_direction;
      end
      if (bus.out_valid) begin
        tests_run++;
        if (out_q.size() == 0) begin
          tests_failed++;
          $display("FAIL out_unexpected data=%h required no beat", bus.out_data);
        end else begin
          e = out_q.pop_front();
          if (bus.out_data !== e || bus.out_last !== ((out_count - out_base) == N - 1)) begin
            tests_failed++;
            $display("FAIL out_beat idx=%0d data=%h last=%b required data=%h last=%b",
                     out_count - out_base, bus.out_data, bus.out_last, e, (out_count - out_base) == N - 1);
          end
        end
        out_count++;
      end
`ifndef FFT_SCHED_TIMEOUT_EN
      if (timeout_err) begin
        tests_failed++;
        $display("FAIL timeout_err got=1 required=0");
      end
`endif
    end
  end

  task automatic do_frame(input logic [1:0] req_v, input int drop_at, input int stall,
                          input bit use_k, input bit exp_dir,
                          output logic [1:0] gnt_seen, output int gnt_lat, output bit busy_seen,
                          output int early_starts, output int beats, output bit done_ok);
    logic [W-1:0] d;
    int guard;
    int s0;
    wr_base = wr_count; out_base = out_count; s0 = start_count;
    beats = 0; early_starts = 0; gnt_lat = 0;
    bus.req = req_v;
    do begin
      @(negedge clk);
      gnt_lat++;
    end while (bus.gnt == 2'b00 && gnt_lat < 20);
    gnt_seen = bus.gnt;
    busy_seen = busy;
    for (int k = 0; k < N; k++) begin
      if (k == drop_at) bus.req = bus.req & 2'b01;
      d = use_k ? W'(k) : W'({$urandom, $urandom});
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      wr_q.push_back(d);
      out_q.push_back(exp_dir ? ~d : d);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      #1 early_starts = start_count - s0;
      bus.core_ready = 1'b1;
    end
    guard = 0;
    while (!(bus.out_valid && bus.out_last) && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (bus.out_valid) beats++;
    end
    done_ok = (guard < 4000);
    #1;
    start_count = start_count - s0;
  endtask

  task automatic test_reset();
    tests_run++; if (bus.gnt !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt got=%b required=00", bus.gnt); end
    tests_run++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_ready got=%b%b required=00", busy, bus.in_ready); end
    tests_run++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_out got=%b%b%b required=000", bus.out_valid, bus.out_last, timeout_err); end
    tests_run++; if ({bus.core_start, bus.core_write_enable, bus.core_read_enable, bus.core_direction, bus.core_real_mode} !== 5'b0) begin tests_failed++; $display("FAIL reset_core_ctl got=%b required=00000", {bus.core_start, bus.core_write_enable, bus.core_read_enable, bus.core_direction, bus.core_real_mode}); end
    tests_run++; if (bus.core_log_depth !== 4'd9) begin tests_failed++; $display("FAIL reset_log_depth got=%0d required=9", bus.core_log_depth); end
    tests_run++; if (bus.core_address !== '0 || bus.core_write_data !== '0) begin tests_failed++; $display("FAIL reset_addr_data got=%0d/%h required=0/0", bus.core_address, bus.core_write_data); end
  endtask

  task automatic test_arbitration();
    logic [1:0] want [3];
    logic [1:0] g; int lat, es, beats; bit b, ok;
    want = '{2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      do_frame(2'b11, -1, 0, 1'b0, want[i][1], g, lat, b, es, beats, ok);
      tests_run++; if (g !== want[i]) begin tests_failed++; $display("FAIL arb_gnt frame=%0d got=%b required=%b", i, g, want[i]); end
      tests_run++; if (beats !== N || !ok) begin tests_failed++; $display("FAIL arb_beats frame=%0d got=%0d required=%0d", i, beats, N); end
    end
    bus.req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [1:0] g; int lat, es, beats; bit b, ok;
    do_frame(2'b01, -1, 0, 1'b1, 1'b0, g, lat, b, es, beats, ok);
    bus.req = 2'b00;
    tests_run++; if (g !== 2'b01 || lat !== 1) begin tests_failed++; $display("FAIL basic_gnt got=%b lat=%0d required=01 lat=1", g, lat); end
    tests_run++; if (b !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_with_gnt got=%b required=1", b); end
    tests_run++; if (wr_count - wr_base !== N) begin tests_failed++; $display("FAIL basic_writes got=%0d required=%0d", wr_count - wr_base, N); end
    tests_run++; if (start_count !== 1 || start_dir !== DIR_FWD) begin tests_failed++; $display("FAIL basic_start got=%0d dir=%b required=1 dir=0", start_count, start_dir); end
    tests_run++; if (beats !== N || !ok) begin tests_failed++; $display("FAIL basic_beats got=%0d required=%0d", beats, N); end
    @(negedge clk);
    tests_run++; if (bus.gnt !== 2'b00 || busy !== 1'b0) begin tests_failed++; $display("FAIL basic_release gnt=%b busy=%b required=00/0", bus.gnt, busy); end
  endtask

  task automatic test_drop_req();
    logic [1:0] g; int lat, es, beats; bit b, ok;
    do_frame(2'b10, 256, 0, 1'b0, 1'b1, g, lat, b, es, beats, ok);
    tests_run++; if (g !== 2'b10) begin tests_failed++; $display("FAIL drop_gnt got=%b required=10", g); end
    tests_run++; if (start_dir !== DIR_INV) begin tests_failed++; $display("FAIL drop_dir got=%b required=1", start_dir); end
    tests_run++; if (beats !== N || !ok) begin tests_failed++; $display("FAIL drop_beats got=%0d required=%0d", beats, N); end
    @(negedge clk);
  endtask

  task automatic test_ready_stall();
    logic [1:0] g; int lat, es, beats; bit b, ok;
    bus.core_ready = 1'b0;
    do_frame(2'b01, -1, 20, 1'b0, 1'b0, g, lat, b, es, beats, ok);
    bus.req = 2'b00;
    tests_run++; if (es !== 0) begin tests_failed++; $display("FAIL stall_early_start got=%0d required=0", es); end
    tests_run++; if (start_count !== 1) begin tests_failed++; $display("FAIL stall_start_count got=%0d required=1", start_count); end
    tests_run++; if (beats !== N || !ok) begin tests_failed++; $display("FAIL stall_beats got=%0d required=%0d", beats, N); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [1:0] g; int lat, es, beats, guard; bit b, ok;
    logic [W-1:0] d;
    wr_base = wr_count;
    bus.req = 2'b01;
    guard = 0;
    do begin @(negedge clk); guard++; end while (bus.gnt == 2'b00 && guard < 20);
    for (int k = 0; k < 200; k++) begin
      d = W'({$urandom, $urandom});
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      wr_q.push_back(d);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (bus.gnt !== 2'b00 || busy !== 1'b0 || bus.core_write_enable !== 1'b0) begin tests_failed++; $display("FAIL midreset gnt=%b busy=%b we=%b required=00/0/0", bus.gnt, busy, bus.core_write_enable); end
    bus.in_valid = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_q.delete();
    out_q.delete();
    first_addr = -1;
    do_frame(2'b11, -1, 0, 1'b0, 1'b0, g, lat, b, es, beats, ok);
    bus.req = 2'b00;
    tests_run++; if (g !== 2'b01) begin tests_failed++; $display("FAIL midreset_rr got=%b required=01", g); end
    tests_run++; if (first_addr !== 0 || wr_count - wr_base !== N) begin tests_failed++; $display("FAIL midreset_restart first=%0d writes=%0d required=0/%0d", first_addr, wr_count - wr_base, N); end
    tests_run++; if (beats !== N || !ok) begin tests_failed++; $display("FAIL midreset_beats got=%0d required=%0d", beats, N); end
    @(negedge clk);
  endtask

`ifdef FFT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int guard, run_cycles, outs;
    hang = 1'b1;
    bus.req = 2'b01;
    guard = 0;
    do begin @(negedge clk); guard++; end while (bus.gnt == 2'b00 && guard < 20);
    bus.req = 2'b00;
    wr_base = wr_count;
    for (int k = 0; k < N; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(k);
      wr_q.push_back(W'(k));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.core_start && guard < 20) begin @(negedge clk); guard++; end
    run_cycles = 0; outs = 0;
    while (!timeout_err && run_cycles < 400) begin
      @(negedge clk);
      run_cycles++;
      if (bus.out_valid) outs++;
    end
    tests_run++; if (run_cycles !== 100) begin tests_failed++; $display("FAIL timeout_cycle got=%0d required=100", run_cycles); end
    tests_run++; if (outs !== 0) begin tests_failed++; $display("FAIL timeout_outputs got=%0d required=0", outs); end
    tests_run++; if (bus.gnt !== 2'b00 || busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_idle gnt=%b busy=%b required=00/0", bus.gnt, busy); end
    @(negedge clk);
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_pulse_width got=1 required=0"); end
    hang = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.req = 2'b00;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.core_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_arbitration();
    test_basic();
    test_drop_req();
    test_ready_stall();
    test_reset_mid();
`ifdef FFT_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit reached required finish earlier");
    $fatal(1, "time limit");
  end

endmodule
